mat_pair_loader: RTL and testbench

- Upstream feeder for the matrix-multiply stage: accepts a serial element stream over a valid/ready handshake and assembles the packed A (MxN) and B (NxL) operand buses.
- Once both matrices are complete, it presents them with mat_valid and holds them stable until the consumer acknowledges.
- The consumer can then use them as its mat_a/mat_b inputs without touching packing logic.
- Frame integrity is checked with an in_last marker. Malformed frames are dropped and flagged.

---
 rtl/mat_pair_loader.sv | 114 +++++++++++
 tb/tb_mat_pair_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_pair_loader.sv
// Assembles a serial row-major element stream into packed A (MxN) and B (NxL) operand buses.
// Latency: mat_valid rises on the edge of the final B transfer; in_ready returns on the edge after mat_ack.
// Backpressure: in_ready drops while a complete frame waits for mat_ack; malformed frames pulse frame_err.
module mat_pair_loader #(
    parameter int M     = 2,
    parameter int N     = 2,
    parameter int L     = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [M*N*WIDTH-1:0]     mat_a,
    output logic [N*L*WIDTH-1:0]     mat_b,
    output logic                     mat_valid,
    input  logic                     mat_ack,
    output logic                     frame_err
);

    localparam int NA = M * N;
    localparam int NB = N * L;
    localparam int F  = NA + NB;
    localparam int IW = $clog2(F) + 1;

    if (M < 1 || N < 1 || L < 1) begin : g_param_check
        $fatal(1, "mat_pair_loader: M, N and L must all be >= 1");
    end

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          xfer;
    logic          a_final;
    logic          b_final;

    assign xfer    = in_valid && in_ready;
    assign a_final = (idx == IW'(NA - 1));
    assign b_final = (idx == IW'(NB - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD_A;
            idx       <= '0;
            in_ready  <= 1'b0;
            mat_a     <= '0;
            mat_b     <= '0;
            mat_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                LOAD_A: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        for (int i = 0; i < NA; i++) begin
                            if (idx == IW'(i)) mat_a[i*WIDTH +: WIDTH] <= in_data;
                        end
                        // in_last can never be legal inside A: drop the frame, element consumed
                        if (in_last) begin
                            frame_err <= 1'b1;
                            idx       <= '0;
                        end else if (a_final) begin
                            state <= LOAD_B;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        for (int i = 0; i < NB; i++) begin
                            if (idx == IW'(i)) mat_b[i*WIDTH +: WIDTH] <= in_data;
                        end
                        if (b_final && in_last) begin
                            state     <= HOLD;
                            mat_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            idx       <= '0;
                        end else if (b_final || in_last) begin
                            frame_err <= 1'b1;
                            state     <= LOAD_A;
                            idx       <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (mat_ack) begin
                        state     <= LOAD_A;
                        mat_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        idx       <= '0;
                    end
                end
                default: begin
                    state <= LOAD_A;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_pair_loader.sv
// Scoreboarded bench for mat_pair_loader: a stream-level model predicts frames and framing errors.
module tb_mat_pair_loader;
    localparam int M = 2, N = 2, L = 2, W = 8;
    localparam int NA = M * N, NB = N * L, F = NA + NB;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic [W-1:0]    in_data = '0;
    logic            in_last = 1'b0;
    logic            in_ready;
    logic [NA*W-1:0] mat_a;
    logic [NB*W-1:0] mat_b;
    logic            mat_valid;
    logic            mat_ack = 1'b0;
    logic            frame_err;

    mat_pair_loader #(.M(M), .N(N), .L(L), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mat_a(mat_a), .mat_b(mat_b),
        .mat_valid(mat_valid), .mat_ack(mat_ack), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [NA*W-1:0] a;
        logic [NB*W-1:0] b;
        int              cyc;
    } frame_t;

    frame_t       exp_q[$];
    int           err_q[$];
    logic [W-1:0] elems[$];
    int           rise_cyc[$];
    int           err_seen = 0;
    int           valid_cycles = 0;

    // Reference model: gathers accepted elements; a frame is good only if in_last lands exactly on element F.
    always @(negedge clk) begin : model
        frame_t fr;
        if (reset) begin
            elems.delete();
        end else if (in_valid && in_ready) begin
            elems.push_back(in_data);
            if (in_last || elems.size() == F) begin
                if (in_last && elems.size() == F) begin
                    for (int k = 0; k < NA; k++) fr.a[k*W +: W] = elems[k];
                    for (int k = 0; k < NB; k++) fr.b[k*W +: W] = elems[NA + k];
                    fr.cyc = cyc + 1;
                    exp_q.push_back(fr);
                end else begin
                    err_q.push_back(cyc + 1);
                end
                elems.delete();
            end
        end
    end

    logic            prev_valid = 1'b0;
    logic [NA*W-1:0] held_a;
    logic [NB*W-1:0] held_b;

    always @(negedge clk) begin : monitor
        frame_t e;
        if (reset) begin
            chk("reset_in_ready", in_ready, 0);
            chk("reset_mat_valid", mat_valid, 0);
            chk("reset_frame_err", frame_err, 0);
            chk("reset_mat_a", mat_a, 0);
            chk("reset_mat_b", mat_b, 0);
            prev_valid = 1'b0;
        end else begin
            if (mat_valid) valid_cycles++;
            if (mat_valid && !prev_valid) begin
                rise_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_mat_valid", mat_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_mat_a", mat_a, e.a);
                    chk("sb_mat_b", mat_b, e.b);
                    chk("sb_valid_cycle", cyc, e.cyc);
                end
                held_a = mat_a;
                held_b = mat_b;
            end else if (mat_valid) begin
                chk("hold_mat_a", mat_a, held_a);
                chk("hold_mat_b", mat_b, held_b);
            end
            if (mat_valid) chk("in_ready_in_hold", in_ready, 0);
            if (frame_err) begin
                err_seen++;
                if (err_q.size() == 0) chk("unexpected_frame_err", frame_err, 0);
                else chk("sb_frame_err_cycle", cyc, err_q.pop_front());
            end
            prev_valid = mat_valid;
        end
    end

    bit ack_const = 1'b0;
    int ack_delay = 3;
    int hold_cnt = 0;

    always @(negedge clk) begin
        if (ack_const) begin
            mat_ack = 1'b1;
        end else if (mat_valid) begin
            hold_cnt++;
            mat_ack = (hold_cnt >= ack_delay);
        end else begin
            hold_cnt = 0;
            mat_ack = 1'b0;
        end
    end

    logic [W-1:0] vals[16];

    task automatic send_elem(input logic [W-1:0] d, input bit last, input bit toggle);
        int waited = 0;
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            ok = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!ok && waited < 200);
        if (!ok) chk("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (toggle) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_seq(input int n, input int last_pos, input bit toggle);
        for (int k = 0; k < n; k++) send_elem(vals[k], (k == last_pos), toggle);
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!mat_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, mat_valid, 1);
    endtask

    task automatic wait_release(input string name);
        int t = 0;
        while (mat_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, mat_valid, 0);
    endtask

    task automatic fill_vals(input int base);
        for (int k = 0; k < 16; k++) vals[k] = W'(base + k);
    endtask

    initial begin
        int e0;
        int kind;
        int n;
        int t;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("in_ready_at_release", in_ready, 0);
        @(posedge clk);
        #1;
        chk("in_ready_first_edge", in_ready, 1);

        // Basic frame, ack 3 cycles after mat_valid
        ack_delay = 3;
        fill_vals(1);
        send_seq(8, 7, 1'b0);
        chk("t1_valid_latency", mat_valid, 1);
        chk("t1_mat_a", mat_a, 32'h04030201);
        chk("t1_mat_b", mat_b, 32'h08070605);
        chk("t1_in_ready_hold", in_ready, 0);
        wait_release("t1_release");

        // Toggling valid, negative element
        e0 = err_seen;
        fill_vals(1);
        vals[4] = 8'hFF;
        send_seq(8, 7, 1'b1);
        wait_valid("t2_valid");
        chk("t2_mat_a", mat_a, 32'h04030201);
        chk("t2_mat_b", mat_b, 32'h080706FF);
        chk("t2_b0_neg", mat_b[7:0], 8'hFF);
        chk("t2_no_err", err_seen - e0, 0);
        wait_release("t2_release");

        // Early in_last on first B element, then a good frame
        e0 = err_seen;
        fill_vals(1);
        send_seq(5, 4, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_err_count", err_seen - e0, 1);
        chk("t3_no_valid", mat_valid, 0);
        fill_vals(8'h41);
        send_seq(8, 7, 1'b0);
        wait_valid("t3_recover_valid");
        chk("t3_recover_a", mat_a, 32'h44434241);
        chk("t3_recover_b", mat_b, 32'h48474645);
        wait_release("t3_release");

        // Missing in_last on final element
        e0 = err_seen;
        fill_vals(1);
        send_seq(8, -1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_err_count", err_seen - e0, 1);
        chk("t4_no_valid", mat_valid, 0);
        chk("t4_in_ready", in_ready, 1);

        // Back-to-back with ack held high
        ack_const = 1'b1;
        rise_cyc.delete();
        valid_cycles = 0;
        fill_vals(8'h11);
        send_seq(8, 7, 1'b0);
        fill_vals(8'h21);
        send_seq(8, 7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_frames", rise_cyc.size(), 2);
        if (rise_cyc.size() == 2) chk("t5_period", rise_cyc[1] - rise_cyc[0], 9);
        chk("t5_valid_cycles", valid_cycles, 2);
        chk("t5_second_a", mat_a, 32'h24232221);
        chk("t5_second_b", mat_b, 32'h28272625);
        ack_const = 1'b0;

        // Reset mid-frame
        fill_vals(1);
        send_seq(6, -1, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t6_in_ready_release", in_ready, 0);
        @(posedge clk);
        #1;
        chk("t6_in_ready_edge", in_ready, 1);
        fill_vals(8'h31);
        send_seq(8, 7, 1'b0);
        wait_valid("t6_valid");
        chk("t6_mat_a", mat_a, 32'h34333231);
        chk("t6_mat_b", mat_b, 32'h38373635);
        wait_release("t6_release");

        // Randomized frames, errors, gaps and ack delays
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < 16; k++) vals[k] = W'($urandom);
            ack_delay = $urandom_range(0, 4);
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                send_seq(8, 7, 1'($urandom_range(0, 1)));
            end else if (kind == 2) begin
                n = $urandom_range(1, 7);
                send_seq(n, n - 1, 1'($urandom_range(0, 1)));
            end else begin
                send_seq(8, -1, 1'($urandom_range(0, 1)));
            end
        end

        t = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0 || mat_valid) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_frames", exp_q.size(), 0);
        chk("drain_errors", err_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
